// File: rtl/cycle_sequencer.sv
// cycle_sequencer: machine-cycle and beat timing generator for the multi-cycle CPU.
// Sequences HALT -> FETCH(T1,T2) -> EXEC(T1..last_beat) and handles run/step,
// a bus-hang watchdog, illegal-instruction flagging and a retired-instruction count.
module cycle_sequencer #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             step,
  input  logic             clear_fault,
  input  logic             done,
  input  logic             ins_ADD,
  input  logic             ins_SUB,
  input  logic             ins_ADDI,
  input  logic             ins_LUI,
  input  logic             ins_JAL,
  input  logic             ins_SW,
  input  logic             ins_LW,
  output logic             Mif,
  output logic             Mex,
  output logic             T1,
  output logic             T2,
  output logic             T3,
  output logic             T4,
  output logic             halted,
  output logic             fault,
  output logic             illegal,
  output logic             retire,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [1:0] S_HALT  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  localparam logic [1:0] B_T1 = 2'd0;
  localparam logic [1:0] B_T2 = 2'd1;
  localparam logic [1:0] B_T3 = 2'd2;
  localparam logic [1:0] B_T4 = 2'd3;

  // Stall count at which one more stalled cycle trips the watchdog.
  localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0] r_state;
  logic [1:0] r_beat;
  logic [1:0] r_lastBeat;
  logic [7:0] r_wdCount;
  logic       r_stepPend;

  logic [1:0] w_nextState;
  logic [1:0] w_nextBeat;
  logic [1:0] w_nextLast;
  logic       w_nextStepPend;
  logic       w_complete;
  logic       w_enterExec;
  logic       w_stall;
  logic       w_expire;
  logic [1:0] w_flagLast;
  logic       w_noFlag;
  logic       w_nextActive;

  // Final beat of the decoded instruction; loads outrank stores outrank the rest.
  always_comb begin
    w_noFlag = ~|{ins_ADD, ins_SUB, ins_ADDI, ins_LUI, ins_JAL, ins_SW, ins_LW};
    if (ins_LW) begin
      w_flagLast = B_T3;
    end else if (ins_SW) begin
      w_flagLast = B_T2;
    end else begin
      w_flagLast = B_T1;
    end
  end

  // Next-state logic; a watchdog expiry overrides whatever the beat would have done.
  always_comb begin
    w_nextState    = r_state;
    w_nextBeat     = r_beat;
    w_nextLast     = r_lastBeat;
    w_nextStepPend = r_stepPend;
    w_complete     = 1'b0;
    w_enterExec    = 1'b0;
    w_stall        = 1'b0;
    case (r_state)
      S_HALT: begin
        if (run || step) begin
          w_nextState = S_FETCH;
          w_nextBeat  = B_T1;
          if (step && !run) begin
            w_nextStepPend = 1'b1;
          end
        end
      end
      S_FETCH: begin
        if (r_beat == B_T1) begin
          w_nextBeat = B_T2;
        end else if (done) begin
          w_nextState = S_EXEC;
          w_nextBeat  = B_T1;
          w_nextLast  = w_flagLast;
          w_enterExec = 1'b1;
        end else begin
          w_stall = 1'b1;
        end
      end
      S_EXEC: begin
        if (!done) begin
          w_stall = 1'b1;
        end else if (r_beat >= r_lastBeat) begin
          w_complete = 1'b1;
          w_nextBeat = B_T1;
          if (run && !r_stepPend) begin
            w_nextState = S_FETCH;
          end else begin
            w_nextState    = S_HALT;
            w_nextStepPend = 1'b0;
          end
        end else begin
          w_nextBeat = r_beat + 2'd1;
        end
      end
      default: begin
        if (clear_fault) begin
          w_nextState = S_HALT;
        end
      end
    endcase
    w_expire = w_stall && (r_wdCount == WD_LIMIT);
    if (w_expire) begin
      w_nextState    = S_FAULT;
      w_nextBeat     = B_T1;
      w_nextStepPend = 1'b0;
    end
  end

  // Sequencer state, latched last beat, step-pending flag and watchdog counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_HALT;
      r_beat     <= B_T1;
      r_lastBeat <= B_T1;
      r_stepPend <= 1'b0;
      r_wdCount  <= 8'd0;
    end else begin
      r_state    <= w_nextState;
      r_beat     <= w_nextBeat;
      r_lastBeat <= w_nextLast;
      r_stepPend <= w_nextStepPend;
      r_wdCount  <= (w_stall && !w_expire) ? r_wdCount + 8'd1 : 8'd0;
    end
  end

  assign w_nextActive = (w_nextState == S_FETCH) || (w_nextState == S_EXEC);

  // Registered outputs, decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Mif         <= 1'b0;
      Mex         <= 1'b0;
      T1          <= 1'b0;
      T2          <= 1'b0;
      T3          <= 1'b0;
      T4          <= 1'b0;
      halted      <= 1'b1;
      fault       <= 1'b0;
      illegal     <= 1'b0;
      retire      <= 1'b0;
      instr_count <= '0;
    end else begin
      Mif     <= (w_nextState == S_FETCH);
      Mex     <= (w_nextState == S_EXEC);
      T1      <= w_nextActive && (w_nextBeat == B_T1);
      T2      <= w_nextActive && (w_nextBeat == B_T2);
      T3      <= w_nextActive && (w_nextBeat == B_T3);
      T4      <= w_nextActive && (w_nextBeat == B_T4);
      halted  <= (w_nextState == S_HALT) || (w_nextState == S_FAULT);
      fault   <= (w_nextState == S_FAULT);
      illegal <= w_enterExec && w_noFlag;
      retire  <= w_complete;
      if (w_complete) begin
        instr_count <= instr_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cycle_sequencer.sv
// tb_cycle_sequencer: directed scenarios plus randomized run against a
// behavioural model of the sequencer. A second, narrow-counter instance
// shares all inputs so counter wrap-around can be observed cheaply.
module tb_cycle_sequencer;

  localparam int TIMEOUT    = 4;
  localparam int MODE_HALT  = 0;
  localparam int MODE_FETCH = 1;
  localparam int MODE_EXEC  = 2;
  localparam int MODE_FAULT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic run = 1'b0, step = 1'b0, clear_fault = 1'b0, done = 1'b0;
  logic ins_ADD = 1'b0, ins_SUB = 1'b0, ins_ADDI = 1'b0, ins_LUI = 1'b0;
  logic ins_JAL = 1'b0, ins_SW = 1'b0, ins_LW = 1'b0;

  logic Mif, Mex, T1, T2, T3, T4, halted, fault, illegal, retire;
  logic [31:0] instr_count;
  logic sMif, sMex, sT1, sT2, sT3, sT4, sHalted, sFault, sIllegal, sRetire;
  logic [2:0] smallCount;

  logic [9:0] obs;
  logic [9:0] smallObs;
  assign obs      = {Mif, Mex, T1, T2, T3, T4, halted, fault, illegal, retire};
  assign smallObs = {sMif, sMex, sT1, sT2, sT3, sT4, sHalted, sFault, sIllegal, sRetire};

  int nChecks = 0;
  int nErrors = 0;

  // Behavioural model state
  int          mMode;
  int          mBeat;
  int          mLast;
  int          mStall;
  bit          mPend;
  logic [31:0] mCount;
  bit          eIllegal;
  bit          eRetire;

  always #5 clk = ~clk;

  cycle_sequencer #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step), .clear_fault(clear_fault), .done(done),
    .ins_ADD(ins_ADD), .ins_SUB(ins_SUB), .ins_ADDI(ins_ADDI), .ins_LUI(ins_LUI),
    .ins_JAL(ins_JAL), .ins_SW(ins_SW), .ins_LW(ins_LW),
    .Mif(Mif), .Mex(Mex), .T1(T1), .T2(T2), .T3(T3), .T4(T4),
    .halted(halted), .fault(fault), .illegal(illegal), .retire(retire),
    .instr_count(instr_count)
  );

  cycle_sequencer #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(3)) smallDut (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step), .clear_fault(clear_fault), .done(done),
    .ins_ADD(ins_ADD), .ins_SUB(ins_SUB), .ins_ADDI(ins_ADDI), .ins_LUI(ins_LUI),
    .ins_JAL(ins_JAL), .ins_SW(ins_SW), .ins_LW(ins_LW),
    .Mif(sMif), .Mex(sMex), .T1(sT1), .T2(sT2), .T3(sT3), .T4(sT4),
    .halted(sHalted), .fault(sFault), .illegal(sIllegal), .retire(sRetire),
    .instr_count(smallCount)
  );

  // Drive all inputs; flags are {ADD, SUB, ADDI, LUI, JAL, SW, LW}.
  task automatic applyStimulus(input logic r, input logic s, input logic cf,
                               input logic d, input logic [6:0] flags);
    run         = r;
    step        = s;
    clear_fault = cf;
    done        = d;
    {ins_ADD, ins_SUB, ins_ADDI, ins_LUI, ins_JAL, ins_SW, ins_LW} = flags;
  endtask

  task automatic modelReset();
    mMode    = MODE_HALT;
    mBeat    = 1;
    mLast    = 1;
    mStall   = 0;
    mPend    = 1'b0;
    mCount   = 32'd0;
    eIllegal = 1'b0;
    eRetire  = 1'b0;
  endtask

  // One more cycle without progress; the TIMEOUT-th in a row is a fault.
  task automatic modelStall();
    mStall = mStall + 1;
    if (mStall >= TIMEOUT) begin
      mMode  = MODE_FAULT;
      mStall = 0;
      mPend  = 1'b0;
    end
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic modelStep();
    eIllegal = 1'b0;
    eRetire  = 1'b0;
    case (mMode)
      MODE_HALT: begin
        if (run || step) begin
          mPend  = step && !run;
          mMode  = MODE_FETCH;
          mBeat  = 1;
          mStall = 0;
        end
      end
      MODE_FETCH: begin
        if (mBeat == 1) begin
          mBeat = 2;
        end else if (done) begin
          mLast    = ins_LW ? 3 : (ins_SW ? 2 : 1);
          eIllegal = !(ins_ADD || ins_SUB || ins_ADDI || ins_LUI || ins_JAL || ins_SW || ins_LW);
          mMode    = MODE_EXEC;
          mBeat    = 1;
          mStall   = 0;
        end else begin
          modelStall();
        end
      end
      MODE_EXEC: begin
        if (!done) begin
          modelStall();
        end else begin
          mStall = 0;
          if (mBeat < mLast) begin
            mBeat = mBeat + 1;
          end else begin
            eRetire = 1'b1;
            mCount  = mCount + 32'd1;
            mBeat   = 1;
            if (run && !mPend) begin
              mMode = MODE_FETCH;
            end else begin
              mMode = MODE_HALT;
              mPend = 1'b0;
            end
          end
        end
      end
      default: begin
        if (clear_fault) mMode = MODE_HALT;
      end
    endcase
  endtask

  function automatic logic [9:0] modelVec();
    logic act;
    act = (mMode == MODE_FETCH) || (mMode == MODE_EXEC);
    return {mMode == MODE_FETCH, mMode == MODE_EXEC,
            act && mBeat == 1, act && mBeat == 2, act && mBeat == 3, act && mBeat == 4,
            mMode == MODE_HALT || mMode == MODE_FAULT, mMode == MODE_FAULT,
            eIllegal, eRetire};
  endfunction

  // One clock: model consumes current inputs, then outputs settle by the negedge.
  task automatic cycle();
    modelStep();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 7'b0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 7'b0);
    rst_n = 1'b0;
    #1;
    nChecks++;
    if (obs !== 10'b00_0000_1000) begin
      nErrors++;
      $display("[TB] FAIL reset_outputs: got %b expected %b", obs, 10'b00_0000_1000);
    end
    nChecks++;
    if (instr_count !== 32'd0) begin
      nErrors++;
      $display("[TB] FAIL reset_count: got %0d expected 0", instr_count);
    end
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    nChecks++;
    if (obs !== 10'b00_0000_1000) begin
      nErrors++;
      $display("[TB] FAIL reset_idle: got %b expected %b", obs, 10'b00_0000_1000);
    end
  endtask

  task automatic test_add_timing();
    logic [9:0] expVec [0:8];
    bit doneSeq [0:8];
    bit runSeq  [0:8];
    expVec  = '{10'b10_1000_0000, 10'b10_0100_0000, 10'b10_0100_0000, 10'b10_0100_0000,
                10'b01_1000_0000, 10'b10_1000_0001, 10'b10_0100_0000, 10'b01_1000_0000,
                10'b00_0000_1001};
    doneSeq = '{1, 1, 0, 0, 1, 1, 1, 1, 1};
    runSeq  = '{1, 1, 1, 1, 1, 1, 0, 0, 0};
    doReset();
    for (int k = 0; k < 9; k++) begin
      applyStimulus(runSeq[k], 0, 0, doneSeq[k], 7'b1000000);
      cycle();
      nChecks++;
      if (obs !== expVec[k]) begin
        nErrors++;
        $display("[TB] FAIL add_timing cycle %0d: got %b expected %b", k + 1, obs, expVec[k]);
      end
      if (k == 5 || k == 8) begin
        nChecks++;
        if (instr_count !== ((k == 5) ? 32'd1 : 32'd2)) begin
          nErrors++;
          $display("[TB] FAIL add_count cycle %0d: got %0d expected %0d", k + 1, instr_count,
                   (k == 5) ? 1 : 2);
        end
      end
    end
  endtask

  task automatic test_lw_sw();
    logic [9:0] lwExp [0:5];
    logic [9:0] swExp [0:4];
    lwExp = '{10'b10_1000_0000, 10'b10_0100_0000, 10'b01_1000_0000, 10'b01_0100_0000,
              10'b01_0010_0000, 10'b00_0000_1001};
    swExp = '{10'b10_1000_0000, 10'b10_0100_0000, 10'b01_1000_0000, 10'b01_0100_0000,
              10'b00_0000_1001};
    for (int k = 0; k < 6; k++) begin
      applyStimulus(k == 0, 0, 0, 1, 7'b0000001);
      cycle();
      nChecks++;
      if (obs !== lwExp[k]) begin
        nErrors++;
        $display("[TB] FAIL lw_beats cycle %0d: got %b expected %b", k + 1, obs, lwExp[k]);
      end
    end
    for (int k = 0; k < 5; k++) begin
      applyStimulus(k == 0, 0, 0, 1, 7'b0000010);
      cycle();
      nChecks++;
      if (obs !== swExp[k]) begin
        nErrors++;
        $display("[TB] FAIL sw_beats cycle %0d: got %b expected %b", k + 1, obs, swExp[k]);
      end
    end
    nChecks++;
    if (instr_count !== 32'd4) begin
      nErrors++;
      $display("[TB] FAIL lw_sw_count: got %0d expected 4", instr_count);
    end
  endtask

  task automatic test_step();
    logic [9:0] expVec [0:4];
    bit stepSeq [0:4];
    expVec  = '{10'b10_1000_0000, 10'b10_0100_0000, 10'b01_1000_0000, 10'b00_0000_1001,
                10'b00_0000_1000};
    stepSeq = '{1, 0, 1, 0, 0};
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, stepSeq[k], 0, 1, 7'b0010000);
      cycle();
      nChecks++;
      if (obs !== expVec[k]) begin
        nErrors++;
        $display("[TB] FAIL step cycle %0d: got %b expected %b", k + 1, obs, expVec[k]);
      end
    end
    nChecks++;
    if (instr_count !== 32'd5) begin
      nErrors++;
      $display("[TB] FAIL step_count: got %0d expected 5", instr_count);
    end
  endtask

  task automatic test_illegal();
    logic [9:0] expVec [0:3];
    expVec = '{10'b10_1000_0000, 10'b10_0100_0000, 10'b01_1000_0010, 10'b00_0000_1001};
    for (int k = 0; k < 4; k++) begin
      applyStimulus(k == 0, 0, 0, 1, 7'b0);
      cycle();
      nChecks++;
      if (obs !== expVec[k]) begin
        nErrors++;
        $display("[TB] FAIL illegal cycle %0d: got %b expected %b", k + 1, obs, expVec[k]);
      end
    end
  endtask

  task automatic test_timeout();
    logic [9:0] expVec [0:11];
    bit runSeq  [0:11];
    bit stepSeq [0:11];
    bit clrSeq  [0:11];
    bit doneSeq [0:11];
    expVec  = '{10'b10_1000_0000, 10'b10_0100_0000, 10'b10_0100_0000, 10'b10_0100_0000,
                10'b10_0100_0000, 10'b00_0000_1100, 10'b00_0000_1100, 10'b00_0000_1000,
                10'b10_1000_0000, 10'b10_0100_0000, 10'b01_1000_0000, 10'b00_0000_1001};
    runSeq  = '{1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0};
    stepSeq = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    clrSeq  = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    doneSeq = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
    for (int k = 0; k < 12; k++) begin
      applyStimulus(runSeq[k], stepSeq[k], clrSeq[k], doneSeq[k], 7'b1000000);
      cycle();
      nChecks++;
      if (obs !== expVec[k]) begin
        nErrors++;
        $display("[TB] FAIL timeout cycle %0d: got %b expected %b", k + 1, obs, expVec[k]);
      end
    end
  endtask

  task automatic test_count_wrap();
    doReset();
    for (int k = 0; k < 25; k++) begin
      applyStimulus(1, 0, 0, 1, 7'b1000000);
      cycle();
    end
    nChecks++;
    if (instr_count !== 32'd8 || smallCount !== 3'd0 || sFault !== 1'b0) begin
      nErrors++;
      $display("[TB] FAIL wrap_8: got count=%0d small=%0d fault=%b expected 8 0 0",
               instr_count, smallCount, sFault);
    end
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 0, 1, 7'b1000000);
      cycle();
    end
    nChecks++;
    if (instr_count !== 32'd9 || smallCount !== 3'd1 || halted !== 1'b1) begin
      nErrors++;
      $display("[TB] FAIL wrap_9: got count=%0d small=%0d halted=%b expected 9 1 1",
               instr_count, smallCount, halted);
    end
  endtask

  task automatic test_reset_midop();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 0, 0, 1, 7'b0000001);
      cycle();
    end
    nChecks++;
    if (obs !== 10'b01_0100_0000) begin
      nErrors++;
      $display("[TB] FAIL midop_pre: got %b expected %b", obs, 10'b01_0100_0000);
    end
    rst_n = 1'b0;
    #1;
    nChecks++;
    if (obs !== 10'b00_0000_1000 || instr_count !== 32'd0) begin
      nErrors++;
      $display("[TB] FAIL midop_reset: got %b count=%0d expected %b count=0",
               obs, instr_count, 10'b00_0000_1000);
    end
    modelReset();
    applyStimulus(0, 0, 0, 1, 7'b0000001);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    nChecks++;
    if (obs !== 10'b00_0000_1000 || instr_count !== 32'd0) begin
      nErrors++;
      $display("[TB] FAIL midop_after: got %b count=%0d expected %b count=0",
               obs, instr_count, 10'b00_0000_1000);
    end
  endtask

  task automatic test_random();
    logic r;
    logic [6:0] flags;
    int sel;
    doReset();
    r = 1'b0;
    flags = 7'b1000000;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 19) == 0) r = ~r;
      if (mMode != MODE_EXEC) begin
        sel = $urandom_range(0, 7);
        flags = 7'b0;
        if (sel != 0) flags[sel-1] = 1'b1;
        if ($urandom_range(0, 3) == 0) flags[$urandom_range(0, 6)] = 1'b1;
      end
      applyStimulus(r, $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 99) < 75, flags);
      cycle();
      nChecks++;
      if (obs !== modelVec() || instr_count !== mCount) begin
        nErrors++;
        $display("[TB] FAIL random cycle %0d: got %b count=%0d expected %b count=%0d",
                 k, obs, instr_count, modelVec(), mCount);
      end
      nChecks++;
      if (smallObs !== modelVec() || smallCount !== mCount[2:0]) begin
        nErrors++;
        $display("[TB] FAIL random_small cycle %0d: got %b count=%0d expected %b count=%0d",
                 k, smallObs, smallCount, modelVec(), mCount[2:0]);
      end
    end
  endtask

  initial begin
    modelReset();
    test_reset();
    test_add_timing();
    test_lw_sw();
    test_step();
    test_illegal();
    test_timeout();
    test_count_wrap();
    test_reset_midop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/cycle_sequencer.md
Name: cycle_sequencer

Overview:
- Timing generator for the multi-cycle CPU.
- Produces the machine-cycle flags (Mif, Mex) and the one-hot beat strobes (T1..T4) that drive control_logic.
- Advances beats on control_logic's output_done.
- Also provides run/halt/single-step control, a bus-hang watchdog, illegal-instruction detection and a retired-instruction counter.

Parameters:
- TIMEOUT_CYCLES, 255: consecutive done=0 cycles in one beat before a fault is raised (legal range 1..255).
- CNT_W, 32: width of instr_count.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- run  in  1  level; 1 = execute continuously.
- step  in  1  single-cycle pulse; while halted, execute exactly one instruction.
- clear_fault  in  1  pulse; leaves FAULT state.
- done  in  1  output_done from control_logic; the current beat may complete.
- ins_ADD, ins_SUB, ins_ADDI, ins_LUI, ins_JAL, ins_SW, ins_LW  in  1 each  decoded instruction flags, stable throughout Mex.
- Mif  out  1  fetch machine cycle.
- Mex  out  1  execute machine cycle.
- T1, T2, T3, T4  out  1 each  one-hot beat strobes.
- halted  out  1  sequencer idle.
- fault  out  1  sticky watchdog fault.
- illegal  out  1  one-cycle pulse: Mex entered with no instruction flag set.
- retire  out  1  one-cycle pulse per completed instruction.
- instr_count  out  CNT_W  retired-instruction count, wraps to 0.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - Mif=Mex=T1..T4=0, halted=1, fault=0, illegal=0, retire=0, instr_count=0.
  - State HALT; watchdog counter 0; step-pending flag 0.
- All outputs are registered. Exactly one of {HALT, FETCH, EXEC, FAULT} is active.
- HALT: Mif=Mex=0, T*=0, halted=1.
  - If run=1 or step=1, go to FETCH/T1 next cycle.
  - A step arriving while halted sets step-pending.
- FETCH:
  - Mif=1, halted=0.
  - T1 lasts exactly one cycle (bus transaction issue) and advances unconditionally to T2.
  - T2 holds until done=1, then goes to EXEC/T1.
- EXEC entry:
  - Latch last_beat from the instruction flags: ADD/SUB/ADDI/LUI/JAL -> T1; SW -> T2; LW -> T3.
  - No flag set -> last_beat=T1, illegal pulses for the first EXEC cycle, and the instruction executes as a NOP.
  - Multiple flags: priority LW > SW > others.
  - last_beat never changes during EXEC.
- EXEC:
  - Mex=1.
  - Beat Tn with n<last_beat: advance to Tn+1 when done=1, else hold.
  - Beat Tn with n=last_beat and done=1: the instruction completes.
    - retire=1 and instr_count+1 in the next cycle.
    - Next state is FETCH/T1 if run=1 and step-pending=0; otherwise HALT, clearing step-pending.
  - T4 is never reached with the current instruction set but is encoded; if last_beat=T4 it behaves identically.
- run deasserted mid-instruction: the current instruction completes, then HALT. A run drop during FETCH also completes that instruction.
- step while run=1 or while not halted: ignored.
- Watchdog:
  - Counts cycles in FETCH/T2 and in every EXEC beat while done=0.
  - Cleared on any beat advance.
  - On reaching TIMEOUT_CYCLES: FAULT next cycle.
  - FETCH/T1 is never counted.
- FAULT:
  - Mif=Mex=T*=0, halted=1, fault=1; no retire.
  - clear_fault=1 -> HALT with fault=0.
  - run and step are ignored while in FAULT.
- Simultaneous events:
  - clear_fault and run together: HALT this cycle, FETCH on the following cycle if run is still 1.
  - done=1 in the same cycle the watchdog would expire: the beat advance wins and the counter clears.
- Reset mid-operation: immediate return to reset values, regardless of state; the in-flight instruction is not retired.
- instr_count wraps from 2^CNT_W-1 to 0 without fault.

Test Plan:
1. Reset, then run=1 at cycle 0, ins_ADD=1, done=1 except FETCH/T2 done at cycle 4:
   - Mif T1 at cycle 1; T2 cycles 2-4; Mex T1 cycle 5.
   - retire=1 and Mif T1 at cycle 6; instr_count=1.
2. LW with done=1 every cycle -> Mex T1, T2, T3 on consecutive cycles; retire once; SW -> Mex T1, T2 only.
3. Halted, step pulse -> exactly one fetch+execute, then halted=1 with instr_count +1; second step while executing -> ignored.
4. Zero instruction flags in Mex -> illegal=1 for one cycle, one-beat NOP, retire=1.
5. TIMEOUT_CYCLES=4, done held 0 in FETCH/T2:
   - fault=1 and halted=1 after 4 stalled cycles.
   - clear_fault -> HALT with fault=0; run then resumes fetch.
6. rst_n dropped during Mex T2 of LW -> all outputs immediately reset values, no retire; preset instr_count to 2^32-1 and retire once -> 0.
